// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioner: FSM state encoding and
// default cycle counts for the 12 MHz STEPFPGA board clock.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 240000;    // 20 ms
  localparam int unsigned DEF_LONG_CYCLES     = 12000000;  // 1 s

endpackage

// File: rtl/key_debounce_sync2.sv
// Two-flop synchronizer for asynchronous board inputs; both stages reset to
// RESET_VAL so the output starts at the input's idle level.
module sync2 #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizes the raw key, debounces it with a
// counter-driven FSM and emits a level plus press/release/long-press strobes.
module key_debounce
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic long_press
);

  localparam int unsigned CW = $clog2(LONG_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(LONG_CYCLES - 1);

  logic s2;
  logic raw;

  sync2 #(.RESET_VAL(ACTIVE_LOW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (key_in),
    .q   (s2)
  );

  assign raw = ACTIVE_LOW ? ~s2 : s2;

  key_state_t    state, state_nxt;
  logic [CW-1:0] db_cnt, db_nxt;
  logic [CW-1:0] hold_cnt, hold_nxt;
  logic          long_done, long_done_nxt;
  logic          level_nxt, press_nxt, release_nxt, long_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:         if (raw) state_nxt = PRESS_WAIT;
      PRESS_WAIT:   if (!raw) state_nxt = IDLE;
                    else if (db_cnt == DB_LAST) state_nxt = HELD;
      HELD:         if (!raw) state_nxt = RELEASE_WAIT;
      RELEASE_WAIT: if (raw) state_nxt = HELD;
                    else if (db_cnt == DB_LAST) state_nxt = IDLE;
    endcase
  end

  // long_press fires on the cycle after hold_cnt saturates; long_done keeps
  // it to one strobe per press however long the key stays down.
  always_comb begin
    db_nxt        = db_cnt;
    hold_nxt      = hold_cnt;
    long_done_nxt = long_done;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    long_nxt      = 1'b0;
    unique case (state)
      IDLE: db_nxt = '0;
      PRESS_WAIT: begin
        if (raw && db_cnt != DB_LAST) db_nxt = db_cnt + CW'(1);
        if (raw && db_cnt == DB_LAST) begin
          press_nxt     = 1'b1;
          hold_nxt      = '0;
          long_done_nxt = 1'b0;
        end
      end
      HELD, RELEASE_WAIT: begin
        if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + CW'(1);
        if (hold_cnt == HOLD_LAST && !long_done) begin
          long_nxt      = 1'b1;
          long_done_nxt = 1'b1;
        end
        if (state == HELD) begin
          db_nxt = '0;
        end else if (!raw) begin
          if (db_cnt != DB_LAST) db_nxt = db_cnt + CW'(1);
          else                   release_nxt = 1'b1;
        end
      end
    endcase
    level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      db_cnt      <= db_nxt;
      hold_cnt    <= hold_nxt;
      long_done   <= long_done_nxt;
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
      long_press  <= long_nxt;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with short cycle counts: a run-length
// reference model checked every cycle, a segment table and timing sequences.
module tb_key_debounce;

  localparam int D = 4;
  localparam int L = 20;

  logic clk;
  logic rst;
  logic key_in;
  logic key_level, key_press, key_release, long_press;

  key_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .long_press  (long_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FSM sees the pin two samples late; a change is
  // accepted after D+1 consecutive samples disagreeing with the current level.
  logic d1, d2;
  bit   m_level, m_press, m_rel, m_long;
  int   run, held;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 = 1'b1; d2 = 1'b1;
      m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      run = 0; held = 0;
    end else begin
      bit pressed, was;
      pressed = (d2 == 1'b0);
      d2 = d1;
      d1 = key_in;
      was = m_level;
      m_press = 0; m_rel = 0; m_long = 0;
      if (pressed != m_level) run++;
      else run = 0;
      if (run == D + 1) begin
        m_level = pressed;
        run = 0;
        if (pressed) begin m_press = 1; held = 0; end
        else m_rel = 1;
      end
      if (was) begin
        held++;
        if (held == L) m_long = 1;
      end
    end
  end

  int edge_no = 0;
  always @(posedge clk) edge_no++;

  int press_cnt, rel_cnt, long_cnt;
  int press_edge, rel_edge, long_edge;

  always @(negedge clk) begin
    check("model_level", key_level, m_level);
    check("model_press", key_press, m_press);
    check("model_release", key_release, m_rel);
    check("model_long", long_press, m_long);
    if (key_press && key_release) check("press_and_release", 1, 0);
    if (key_press)   begin press_cnt++; press_edge = edge_no; end
    if (key_release) begin rel_cnt++;   rel_edge   = edge_no; end
    if (long_press)  begin long_cnt++;  long_edge  = edge_no; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    press_cnt = 0; rel_cnt = 0; long_cnt = 0;
    press_edge = -1; rel_edge = -1; long_edge = -1;
  endtask

  typedef struct {
    bit key;
    int n;
    bit lvl;
    int np;
    int nr;
    int nl;
  } vec_t;

  vec_t tbl[$];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first;
    int cycles;

    for (int i = 0; i < 5; i++) begin
      tbl.push_back('{1'b0, 2, 1'b0, 0, 0, 0});
      tbl.push_back('{1'b1, 2, 1'b0, 0, 0, 0});
    end
    tbl.push_back('{1'b1, 6,  1'b0, 0, 0, 0});
    tbl.push_back('{1'b0, 40, 1'b1, 1, 0, 1});
    tbl.push_back('{1'b1, 10, 1'b0, 0, 1, 0});
    tbl.push_back('{1'b0, 12, 1'b1, 1, 0, 0});
    tbl.push_back('{1'b1, 2,  1'b1, 0, 0, 0});
    tbl.push_back('{1'b0, 20, 1'b1, 0, 0, 1});
    tbl.push_back('{1'b1, 10, 1'b0, 0, 1, 0});
    tbl.push_back('{1'b0, 8,  1'b1, 1, 0, 0});
    tbl.push_back('{1'b1, 3,  1'b1, 0, 0, 0});
    tbl.push_back('{1'b0, 3,  1'b1, 0, 0, 0});
    tbl.push_back('{1'b1, 9,  1'b0, 0, 1, 0});

    clear();
    key_in = 1'b1;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("reset_level", key_level, 0);
    check("reset_press", key_press, 0);
    check("reset_release", key_release, 0);
    check("reset_long", long_press, 0);
    repeat (3) tick();
    rst = 1'b0;
    clear();
    repeat (10) tick();
    check("idle_level", key_level, 0);
    check("idle_strobes", press_cnt + rel_cnt + long_cnt, 0);

    // Clean press, long hold, release
    clear();
    key_in = 1'b0;
    first = edge_no + 1;
    repeat (40) tick();
    check("press_edge", press_edge, first + 2 + D);
    check("press_count", press_cnt, 1);
    check("long_edge", long_edge, first + 2 + D + L);
    check("long_count", long_cnt, 1);
    check("held_level", key_level, 1);
    key_in = 1'b1;
    first = edge_no + 1;
    repeat (10) tick();
    check("release_edge", rel_edge, first + 2 + D);
    check("release_count", rel_cnt, 1);
    check("released_level", key_level, 0);

    // Release glitch must not disturb level or long-press timing
    clear();
    key_in = 1'b0;
    first = edge_no + 1;
    repeat (12) tick();
    key_in = 1'b1;
    repeat (2) tick();
    key_in = 1'b0;
    repeat (20) tick();
    check("glitch_release", rel_cnt, 0);
    check("glitch_level", key_level, 1);
    check("glitch_long_edge", long_edge, first + 2 + D + L);
    key_in = 1'b1;
    repeat (10) tick();

    // Asynchronous reset while held, then re-debounce
    clear();
    key_in = 1'b0;
    repeat (12) tick();
    check("pre_reset_level", key_level, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_level", key_level, 0);
    check("async_reset_strobes", {29'd0, key_press, key_release, long_press}, 0);
    tick();
    rst = 1'b0;
    clear();
    first = edge_no + 1;
    repeat (10) tick();
    check("repress_edge", press_edge, first + 2 + D);
    check("repress_count", press_cnt, 1);
    key_in = 1'b1;
    repeat (10) tick();

    // Segment table
    foreach (tbl[i]) begin
      clear();
      key_in = tbl[i].key;
      repeat (tbl[i].n) tick();
      check($sformatf("tbl%0d_level", i), key_level, tbl[i].lvl);
      check($sformatf("tbl%0d_press", i), press_cnt, tbl[i].np);
      check($sformatf("tbl%0d_release", i), rel_cnt, tbl[i].nr);
      check($sformatf("tbl%0d_long", i), long_cnt, tbl[i].nl);
    end

    // Random bursts mixing bounces and long holds, checked by the model
    cycles = 0;
    while (cycles < 4000) begin
      int n;
      key_in = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6))
                                      : int'($urandom_range(8, 40));
      repeat (n) tick();
      cycles += n;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
